// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one external adder between NREQ requesters
// Accepts one operand pair at a time, registers the sum with carry/overflow flags and returns it tagged with the requester id.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_sum,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_carry,
  output logic                    rsp_ovf,
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [IDW:0] NREQ_C = (IDW+1)'(NREQ);

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [IDW:0]   cand;
  logic           accept;

  // Scan from farthest to nearest so the candidate closest to last_grant+1 is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= NREQ_C) begin
        cand = cand - NREQ_C;
      end
      if (req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // req_ready is gated by reset so it reads zero while reset is held, even with requesters valid.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any && wb_rst_ni) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = CALC;
        end
      end
      CALC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      add_a      <= '0;
      add_b      <= '0;
      cur_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      busy       <= 1'b0;
      op_count   <= 16'd0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        add_a      <= req_a[grant_idx*WIDTH +: WIDTH];
        add_b      <= req_b[grant_idx*WIDTH +: WIDTH];
        cur_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == CALC) begin
        rsp_data  <= add_sum;
        rsp_id    <= cur_id;
        rsp_carry <= (add_sum < add_a);
        rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      if (state == RESP && rsp_ready) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter with a behavioural shared adder
module tb_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_ni = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_data;
  logic                  rsp_valid, rsp_ready, rsp_carry, rsp_ovf, busy;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           op_count;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .busy(busy), .op_count(op_count)
  );

  assign add_sum = add_a + add_b;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    int               cyc;
  } exp_t;

  op_t         pend[NREQ][$];
  exp_t        sb[$];
  int          grant_id[$];
  int          grant_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        prev_rv = 1'b0;
  int          exp_order[6];

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    pend[i].push_back(o);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = pend[i][0].a;
        req_b[i*WIDTH +: WIDTH] = pend[i][0].b;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic bit pending_any();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: sample at the falling edge, update requesters just after the rising edge.
  task automatic step();
    int               acc;
    exp_t             e;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    acc = -1;
    @(negedge wb_clk_i);
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) acc = i;
    end
    if (req_ready != '0) check("ready_onehot", $onehot(req_ready), 1);
    if (acc >= 0) begin
      check("ready_has_valid", req_valid[acc], 1);
      a = req_a[acc*WIDTH +: WIDTH];
      b = req_b[acc*WIDTH +: WIDTH];
      s = {1'b0, a} + {1'b0, b};
      e.id    = IDW'(acc);
      e.sum   = s[WIDTH-1:0];
      e.carry = s[WIDTH];
      e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      e.cyc   = cyc;
      sb.push_back(e);
      grant_id.push_back(acc);
      grant_cyc.push_back(cyc);
    end
    if (rsp_valid && !prev_rv) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_latency", cyc - sb[0].cyc, 2);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.sum);
        check("rsp_id", rsp_id, e.id);
        check("rsp_carry", rsp_carry, e.carry);
        check("rsp_ovf", rsp_ovf, e.ovf);
        check("op_count", op_count, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
        hs_cyc = cyc;
      end
    end
    prev_rv = rsp_valid;
    @(posedge wb_clk_i);
    #1;
    if (acc >= 0) pend[acc].delete(0);
    drive();
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((sb.size() > 0 || pending_any() || busy) && n < maxc) begin
      step();
      n++;
    end
    check("drain_timeout", n < maxc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int h;
    int r;
    exp_order = '{0, 1, 2, 3, 0, 1};
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_req_ready", req_ready, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;

    // single op from requester 2
    add_op(2, 32'h0000_0005, 32'h0000_0007);
    drive();
    run_idle(20);
    check("single_grant_cycles", grant_id.size(), 1);
    if (grant_id.size() > 0) check("single_grant_id", grant_id[0], 2);
    check("single_op_count", op_count, 1);

    // carry and overflow flags
    add_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
    add_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
    drive();
    run_idle(30);
    check("flags_op_count", op_count, 3);

    // backpressure with another requester waiting
    grant_id.delete();
    grant_cyc.delete();
    rsp_ready = 1'b0;
    add_op(0, 32'h1234_5678, 32'h1111_1111);
    drive();
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    check("bp_reach_resp", rsp_valid, 1);
    add_op(3, 32'h8000_0000, 32'h8000_0000);
    drive();
    repeat (5) begin
      step();
      check("bp_data", rsp_data, 32'h2345_6789);
      check("bp_valid", rsp_valid, 1);
      check("bp_ready_low", req_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_count", op_count, exp_cnt);
    end
    rsp_ready = 1'b1;
    step();
    h = hs_cyc;
    check("bp_count_once", op_count, exp_cnt);
    run_idle(30);
    check("bp_grants", grant_id.size(), 2);
    if (grant_id.size() == 2) begin
      check("bp_next_id", grant_id[1], 3);
      check("bp_next_gap", grant_cyc[1] - h, 1);
    end

    // reset during CALC, then all four requesters continuously valid
    add_op(1, 32'hAAAA_0000, 32'h0000_5555);
    drive();
    n = 0;
    while (!(busy && !rsp_valid) && n < 10) begin
      step();
      n++;
    end
    check("mid_add_a", add_a, 32'hAAAA_0000);
    add_op(0, 32'h0000_0010, 32'h0000_0001);
    add_op(0, 32'h0000_0020, 32'h0000_0002);
    add_op(1, 32'h0000_0030, 32'h0000_0003);
    add_op(1, 32'h0000_0040, 32'h0000_0004);
    add_op(2, 32'hFFFF_FFF0, 32'h0000_0020);
    add_op(3, 32'h8000_0001, 32'hFFFF_FFFF);
    #1 wb_rst_ni = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_op_count", op_count, 0);
    drive();
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    sb.delete();
    grant_id.delete();
    grant_cyc.delete();
    exp_cnt = 16'd0;
    prev_rv = 1'b0;
    @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    r = cyc;
    run_idle(60);
    check("rr_count", grant_id.size(), 6);
    for (int k = 0; k < 6 && k < grant_id.size(); k++) begin
      check("rr_order", grant_id[k], exp_order[k]);
      if (k == 0) check("rr_first_after_rst", grant_cyc[0] - r, 0);
      else check("rr_gap", grant_cyc[k] - grant_cyc[k-1], 3);
    end
    check("rr_op_count", op_count, 6);

    // counter wrap from a preloaded value
    force dut.op_count = 16'hFFFD;
    #1 release dut.op_count;
    exp_cnt = 16'hFFFD;
    check("wrap_preload", op_count, 16'hFFFD);
    add_op(2, 32'h0000_0001, 32'h0000_0001);
    add_op(2, 32'h0000_0002, 32'h0000_0002);
    add_op(2, 32'h0000_0003, 32'h0000_0003);
    drive();
    run_idle(30);
    check("wrap_zero", op_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares the single 32-bit `simple_adder` instance between up to `NREQ` requesters (Wishbone register block, logic-analyzer port, user logic). It accepts one operand pair at a time, drives the shared adder's inputs from registers, captures the sum with carry and overflow flags, and returns it tagged with the requester ID through a valid/ready response port. It sits in `user_project_wrapper` between the requesters and the adder instance.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand/result width; must match the adder

- `wb_clk_i`  in  1  clock; all state on rising edge
- `wb_rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  per-requester operand-pair valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_a`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  operand B, same packing
- `add_a`  out  WIDTH  registered operand A to shared adder
- `add_b`  out  WIDTH  registered operand B to shared adder
- `add_sum`  in  WIDTH  combinational sum from shared adder
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  WIDTH  registered sum
- `rsp_id`  out  clog2(NREQ)  index of requester that issued the result
- `rsp_carry`  out  1  unsigned carry-out: (rsp_data < captured A)
- `rsp_ovf`  out  1  signed overflow: A,B MSBs equal and sum MSB differs
- `busy`  out  1  high whenever state is not IDLE
- `op_count`  out  16  completed-response counter, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, CALC, RESP. Reset state IDLE.
- IDLE: if any `req_valid` high, select the grant by round-robin. Search starts at `last_grant+1` mod NREQ and wraps. `req_ready[grant]` is high combinationally in this cycle. At the edge: capture `req_a`/`req_b` of the grant into `add_a`/`add_b`, store the grant as `cur_id` and `last_grant`, then go to CALC. If no valid is high, stay in IDLE with all `req_ready` low.
- CALC: the adder settles from `add_a`/`add_b`. At the edge: capture `add_sum`→`rsp_data`, `cur_id`→`rsp_id`, and compute `rsp_carry`/`rsp_ovf` from `add_a`, `add_b` and `add_sum`. Then go to RESP.
- RESP: `rsp_valid`=1. Outputs hold stable while `rsp_ready`=0. On `rsp_valid && rsp_ready`: increment `op_count` and go to IDLE.
- `req_ready` is low in CALC and RESP. Requesters hold `req_valid` and operands until they see ready.
- `add_a`/`add_b` keep their last values after an operation; they are not cleared.
- A requester that drops `req_valid` before it is granted is simply skipped. No error is raised.
- `last_grant` reset value is NREQ-1, so requester 0 wins the first arbitration.
- Arithmetic is modulo 2^WIDTH. `rsp_carry` and `rsp_ovf` are independent flags.

## Timing
- Reset values: `req_ready`=0, `add_a`=0, `add_b`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_carry`=0, `rsp_ovf`=0, `busy`=0, `op_count`=0.
- Latency: accept edge (cycle 0) → `rsp_valid` high in cycle 2.
- Throughput: one operation per 3 cycles when `rsp_ready` is held high. Backpressure adds one cycle per stalled cycle.
- `busy` is registered from the state and is high in CALC and RESP.
- Reset asserted mid-operation: the in-flight operation is dropped, all outputs return to reset values immediately (asynchronous), and the counter clears. After `wb_rst_ni` rises, the first grant is at the next edge where a valid is present.
- A new `req_valid` that arrives while the block is busy is not granted until IDLE.
- Fairness: with all NREQ requesters continuously valid, the grant order is 0,1,…,NREQ-1,0,…; no requester waits more than NREQ operations.

## Test plan
- Single op: requester 2 drives A=0x0000_0005, B=0x0000_0007 → ready[2] pulses 1 cycle; 2 cycles later rsp_valid with data=0x0000_000C, id=2, carry=0, ovf=0; op_count=1.
- Flags: A=0xFFFF_FFFF, B=0x0000_0001 → data=0, carry=1, ovf=0. A=0x7FFF_FFFF, B=0x0000_0001 → data=0x8000_0000, carry=0, ovf=1.
- Round-robin: all 4 valid continuously with rsp_ready=1 → grant/rsp_id order 0,1,2,3,0,1; each grant 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, all req_ready low, busy=1; release → op_count increments once, next grant the following cycle.
- Reset mid-op: drop wb_rst_ni during CALC → rsp_valid=0, busy=0, add_a=0 immediately; after release, requester 0 is granted first.
- Counter wrap: force 65536 completed ops (or preload via bench) → op_count reads 0x0000 after 0xFFFF.
